// File: rtl/status_flag_unit_pkg.sv
// -----------------------------------------------------------------------------
// status_flag_unit_pkg
// Shared definitions for the condition-code stage and for any other block that
// evaluates condition fields (e.g. the branch unit):
//   - COND_EQ .. COND_NV : 4-bit ARM-style condition field encodings
//   - FLAG_N/Z/C/V       : bit positions inside the 4-bit {N,Z,C,V} vector
//   - state_t            : update-path FSM encoding (ST_IDLE, ST_UPDATED)
// -----------------------------------------------------------------------------
package status_flag_unit_pkg;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Update-path FSM
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_UPDATED = 1'b1
    } state_t;

endpackage : status_flag_unit_pkg

// File: rtl/status_flag_unit_cond_evaluator.sv
// -----------------------------------------------------------------------------
// status_flag_unit_cond_evaluator
// Purely combinational ARM-style condition evaluator. Shared between the
// status flag unit and the branch unit.
//
// Parameters:
//   COND_W  : width of the condition field (4)
//   NV_PASS : result for condition 4'b1111 (0 = never, 1 = always)
// Ports:
//   flags  in  [3:0]        {N,Z,C,V}
//   cond   in  [COND_W-1:0] condition field
//   pass   out              condition satisfied
// -----------------------------------------------------------------------------
module status_flag_unit_cond_evaluator
    import status_flag_unit_pkg::*;
#(
    parameter int COND_W  = 4,
    parameter bit NV_PASS = 1'b0
) (
    input  logic [3:0]        flags,
    input  logic [COND_W-1:0] cond,
    output logic              pass
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags[FLAG_N];
    assign flag_z = flags[FLAG_Z];
    assign flag_c = flags[FLAG_C];
    assign flag_v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = flag_z;
            COND_NE: pass = !flag_z;
            COND_CS: pass = flag_c;
            COND_CC: pass = !flag_c;
            COND_MI: pass = flag_n;
            COND_PL: pass = !flag_n;
            COND_VS: pass = flag_v;
            COND_VC: pass = !flag_v;
            COND_HI: pass = flag_c && !flag_z;
            COND_LS: pass = !flag_c || flag_z;
            COND_GE: pass = (flag_n == flag_v);
            COND_LT: pass = (flag_n != flag_v);
            COND_GT: pass = !flag_z && (flag_n == flag_v);
            COND_LE: pass = flag_z || (flag_n != flag_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = NV_PASS;
            default: pass = 1'b0;
        endcase
    end

endmodule : status_flag_unit_cond_evaluator

// File: rtl/status_flag_unit.sv
// -----------------------------------------------------------------------------
// status_flag_unit
// Condition-code stage downstream of the ALU. Holds the NZCV status register,
// feeds registered carry back to the ALU, and qualifies the next instruction
// with cond_pass.
//
// Optional feature (macro FLAG_BYPASS_EN):
//   defined   : cond_pass is evaluated against the next-state flags, so an
//               instruction right after a flag-setting one sees the new flags.
//   undefined : cond_pass uses the registered flags (1-cycle visibility lag).
//   cin is the registered carry in both builds.
//
// Parameters:
//   COND_W  : condition field width (4)
//   NV_PASS : result for condition NV (4'b1111)
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; clears all state
//   alu_z/n/c/v in  ALU flag outputs
//   s_bit      in   load flags from the ALU this cycle
//   stall      in   hold all state
//   wr_en      in   direct flag write (wins over s_bit)
//   wr_data    in   [3:0] direct write value {N,Z,C,V}
//   cond       in   [COND_W-1:0] condition field of the next instruction
//   flags      out  [3:0] registered {N,Z,C,V}
//   cin        out  registered carry to the ALU
//   cond_pass  out  condition satisfied
//   upd_cnt    out  [7:0] flag updates since reset, wraps at 256
// -----------------------------------------------------------------------------
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter int COND_W  = 4,
    parameter bit NV_PASS = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              s_bit,
    input  logic              stall,
    input  logic              wr_en,
    input  logic [3:0]        wr_data,
    input  logic [COND_W-1:0] cond,
    output logic [3:0]        flags,
    output logic              cin,
    output logic              cond_pass,
    output logic [7:0]        upd_cnt
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cin_q;
    logic       cin_d;
    logic [7:0] upd_cnt_q;
    logic [7:0] upd_cnt_d;
    state_t     state_q;
    state_t     state_d;
    logic       upd_accept;
    logic [3:0] eff_flags;

    // -------------------------------------------------------------------------
    // Flag update path. The ALU inputs are only looked at when s_bit selects
    // them, so garbage on alu_* during other cycles never reaches state.
    // -------------------------------------------------------------------------
    always_comb begin
        upd_accept = 1'b0;
        flags_d    = flags_q;
        if (!stall) begin
            if (wr_en) begin
                flags_d    = wr_data;
                upd_accept = 1'b1;
            end else if (s_bit) begin
                flags_d[FLAG_N] = alu_n;
                flags_d[FLAG_Z] = alu_z;
                flags_d[FLAG_C] = alu_c;
                flags_d[FLAG_V] = alu_v;
                upd_accept      = 1'b1;
            end
        end
        // Carry gets its own flop so the ALU sees a clean register output.
        cin_d     = flags_d[FLAG_C];
        upd_cnt_d = upd_accept ? (upd_cnt_q + 8'd1) : upd_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= 4'b0000;
            cin_q     <= 1'b0;
            upd_cnt_q <= 8'd0;
        end else begin
            flags_q   <= flags_d;
            cin_q     <= cin_d;
            upd_cnt_q <= upd_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Update-path FSM. state_q == ST_UPDATED marks flags that were written on
    // the previous edge ("fresh"); stall freezes it along with the flags.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (upd_accept) begin
                        state_d = ST_UPDATED;
                    end
                end
                ST_UPDATED: begin
                    if (!upd_accept) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Condition evaluation
    // -------------------------------------------------------------------------
`ifdef FLAG_BYPASS_EN
    // flags_d already folds in wr_en/s_bit priority and stall, so it is
    // exactly the value the flags will take at the next edge.
    assign eff_flags = flags_d;
`else
    assign eff_flags = flags_q;
`endif

    status_flag_unit_cond_evaluator #(
        .COND_W  (COND_W),
        .NV_PASS (NV_PASS)
    ) u_cond_evaluator (
        .flags (eff_flags),
        .cond  (cond),
        .pass  (cond_pass)
    );

    assign flags   = flags_q;
    assign cin     = cin_q;
    assign upd_cnt = upd_cnt_q;

endmodule : status_flag_unit

// File: tb/tb_status_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_status_flag_unit
// Self-checking bench for status_flag_unit: directed scenarios plus a random
// phase, all compared against a behavioural model of the flag register,
// update counter, fresh indicator and ARM condition rules.
// Honours FLAG_BYPASS_EN when choosing which flags cond_pass should see.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_status_flag_unit;
    import status_flag_unit_pkg::*;

    localparam bit TB_NV_PASS = 1'b0;

    logic       clk;
    logic       reset;
    logic       alu_z, alu_n, alu_c, alu_v;
    logic       s_bit, stall, wr_en;
    logic [3:0] wr_data;
    logic [3:0] cond;
    logic [3:0] flags;
    logic       cin;
    logic       cond_pass;
    logic [7:0] upd_cnt;

    int err_cnt = 0;
    int chk_cnt = 0;
    int tick_no = 0;

    // Reference model state
    logic [3:0] m_flags;
    logic [7:0] m_cnt;
    logic       m_fresh;

    status_flag_unit #(
        .COND_W  (4),
        .NV_PASS (TB_NV_PASS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_z     (alu_z),
        .alu_n     (alu_n),
        .alu_c     (alu_c),
        .alu_v     (alu_v),
        .s_bit     (s_bit),
        .stall     (stall),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .cond      (cond),
        .flags     (flags),
        .cin       (cin),
        .cond_pass (cond_pass),
        .upd_cnt   (upd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, obs, exp, tick_no);
        end
    endtask

    // ARM condition rule: bits [3:1] pick a base predicate, bit 0 inverts it;
    // 1111 is the special NV case.
    function automatic logic exp_pass(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return TB_NV_PASS;
        return base ^ c[0];
    endfunction

    task automatic check_state(input string tag);
        check_val({tag, "_flags"}, 32'(flags), 32'(m_flags));
        check_val({tag, "_cin"}, 32'(cin), 32'(m_flags[1]));
        check_val({tag, "_cnt"}, 32'(upd_cnt), 32'(m_cnt));
        check_val({tag, "_fresh"}, 32'(dut.state_q == ST_UPDATED), 32'(m_fresh));
    endtask

    // One clock edge with whatever inputs are currently driven. Checks
    // cond_pass before the edge, then the registered outputs after it.
    task automatic tick(input string tag);
        logic       upd;
        logic [3:0] nf;
        logic [3:0] eff;
        upd = 1'b0;
        nf  = m_flags;
        if (!stall && wr_en) begin
            nf = wr_data; upd = 1'b1;
        end else if (!stall && s_bit) begin
            nf = {alu_n, alu_z, alu_c, alu_v}; upd = 1'b1;
        end
`ifdef FLAG_BYPASS_EN
        eff = nf;
`else
        eff = m_flags;
`endif
        #1;
        check_val({tag, "_pass"}, 32'(cond_pass), 32'(exp_pass(eff, cond)));
        @(posedge clk);
        #1;
        tick_no++;
        if (!stall) begin
            m_flags = nf;
            m_cnt   = m_cnt + 8'(upd);
            m_fresh = upd;
        end
        $display("tick %0d %s: wr=%b s=%b st=%b cond=%h flags=%h cnt=%0d", tick_no, tag,
                 wr_en, s_bit, stall, cond, flags, upd_cnt);
        check_state(tag);
    endtask

    task automatic idle_inputs();
        s_bit = 1'b0; stall = 1'b0; wr_en = 1'b0; wr_data = 4'h0;
        {alu_n, alu_z, alu_c, alu_v} = 4'h0;
        cond = COND_AL;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_flags = 4'h0; m_cnt = 8'd0; m_fresh = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_flags = 4'h0; m_cnt = 8'd0; m_fresh = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_state("reset");

        // Async reset with flags = 1111: clears without a clock edge
        wr_en = 1'b1; wr_data = 4'hF;
        tick("set_all");
        wr_en = 1'b0;
        #2;
        reset = 1'b1;
        m_flags = 4'h0; m_cnt = 8'd0; m_fresh = 1'b0;
        #1;
        check_val("async_rst_flags", 32'(flags), 32'h0);
        check_val("async_rst_cin", 32'(cin), 32'h0);
        check_val("async_rst_cnt", 32'(upd_cnt), 32'h0);
        cond = COND_EQ; #1;
        check_val("rst_eq_pass", 32'(cond_pass), 32'h0);
        cond = COND_AL; #1;
        check_val("rst_al_pass", 32'(cond_pass), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ALU update n=1 z=0 c=1 v=0
        {alu_n, alu_z, alu_c, alu_v} = 4'b1010; s_bit = 1'b1;
        tick("alu_upd");
        check_val("alu_upd_flags_1010", 32'(flags), 32'hA);
        check_val("alu_upd_cnt_1", 32'(upd_cnt), 32'h1);
        s_bit = 1'b0;
        cond = COND_MI; tick("cond_mi");
        check_val("mi_pass", 32'(cond_pass), 32'h1);
        cond = COND_CS; tick("cond_cs");
        cond = COND_HI; tick("cond_hi");
        cond = COND_GE; tick("cond_ge");
        check_val("ge_pass", 32'(cond_pass), 32'h0);
        cond = COND_LT; tick("cond_lt");

        // wr_en wins over s_bit
        wr_en = 1'b1; wr_data = 4'b0100; s_bit = 1'b1;
        {alu_n, alu_z, alu_c, alu_v} = 4'b1011;
        tick("prio");
        check_val("prio_flags_0100", 32'(flags), 32'h4);
        // Same with stall: nothing moves
        wr_data = 4'b1001; stall = 1'b1;
        tick("stall");
        stall = 1'b1; wr_en = 1'b0;
        tick("stall_hold");
        idle_inputs();

        // X on ALU inputs while s_bit=0
        {alu_n, alu_z, alu_c, alu_v} = 4'bxxxx;
        tick("alu_x");
        idle_inputs();

        // Condition sweep over all flag values and all codes
        for (int f = 0; f < 16; f++) begin
            wr_en = 1'b1; wr_data = 4'(f);
            tick("sweep_wr");
            wr_en = 1'b0;
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                tick("sweep");
            end
        end
        idle_inputs();

        // Bypass: z goes to 1 while EQ is being evaluated
        do_reset();
        cond = COND_EQ; s_bit = 1'b1; alu_z = 1'b1;
        #1;
`ifdef FLAG_BYPASS_EN
        check_val("bypass_same_cycle", 32'(cond_pass), 32'h1);
`else
        check_val("bypass_same_cycle", 32'(cond_pass), 32'h0);
`endif
        tick("bypass");
        s_bit = 1'b0;
        #1;
        check_val("bypass_next_cycle", 32'(cond_pass), 32'h1);
        tick("bypass_after");
        idle_inputs();

        // Reset in the middle of a pending write: the write is lost
        wr_en = 1'b1; wr_data = 4'hE;
        #1;
        do_reset();
        #1;
        check_val("rst_mid_upd_flags", 32'(flags), 32'h0);
        check_val("rst_mid_upd_cnt", 32'(upd_cnt), 32'h0);
        idle_inputs();

        // Counter wrap: 256 updates bring upd_cnt back to 0
        s_bit = 1'b1;
        for (int i = 0; i < 256; i++) begin
            {alu_n, alu_z, alu_c, alu_v} = 4'($urandom_range(0, 15));
            cond = 4'($urandom_range(0, 15));
            tick("wrap");
        end
        check_val("wrap_cnt_zero", 32'(upd_cnt), 32'h0);
        check_val("wrap_fresh", 32'(dut.state_q == ST_UPDATED), 32'h1);
        s_bit = 1'b0;
        tick("wrap_drop");
        check_val("wrap_idle", 32'(dut.state_q == ST_UPDATED), 32'h0);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            stall   = ($urandom_range(0, 4) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            s_bit   = ($urandom_range(0, 1) == 1);
            wr_data = 4'($urandom_range(0, 15));
            {alu_n, alu_z, alu_c, alu_v} = 4'($urandom_range(0, 15));
            cond    = 4'($urandom_range(0, 15));
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_status_flag_unit
